// File: rtl/seq_recombine_pkg.sv
// Shared types for the dividend-reconstruction block.
package seq_recombine_pkg;

    // Controller phases: wait for operands, multiply, add remainder, present result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/seq_recombine_shift_add_step.sv
// One iteration of an unsigned shift-add multiplier: conditionally accumulate the
// multiplicand, then advance multiplicand left and multiplier right.
module seq_recombine_shift_add_step #(
    parameter int unsigned DATAWIDTH = 64
) (
    input  logic [2*DATAWIDTH-1:0] acc,
    input  logic [2*DATAWIDTH-1:0] mcand,
    input  logic [DATAWIDTH-1:0]   mplier,
    output logic [2*DATAWIDTH-1:0] acc_next,
    output logic [2*DATAWIDTH-1:0] mcand_next,
    output logic [DATAWIDTH-1:0]   mplier_next
);

    // Next-state values for a single multiplier bit.
    always_comb begin
        acc_next    = mplier[0] ? (acc + mcand) : acc;
        mcand_next  = mcand << 1;
        mplier_next = mplier >> 1;
    end

endmodule

// File: rtl/seq_recombine.sv
// Reconstructs dividend = quot*divisor + rem with an iterative shift-add multiplier,
// flagging overflow, inconsistent remainders and zero divisors.
module seq_recombine
    import seq_recombine_pkg::*;
#(
    parameter int unsigned DATAWIDTH = 64
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] quot,
    input  logic [DATAWIDTH-1:0] divisor,
    input  logic [DATAWIDTH-1:0] rem,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] dividend,
    output logic                 ovf,
    output logic                 rem_err,
    output logic                 div_zero
);

    localparam int unsigned CW = $clog2(DATAWIDTH) + 1;
    localparam int unsigned PW = 2 * DATAWIDTH;

    state_t               state;
    logic [PW-1:0]        acc;
    logic [PW-1:0]        mcand;
    logic [DATAWIDTH-1:0] mplier;
    logic [DATAWIDTH-1:0] rem_q;
    logic [DATAWIDTH-1:0] div_q;
    logic [CW-1:0]        cnt;

    logic [PW-1:0]        acc_next;
    logic [PW-1:0]        mcand_next;
    logic [DATAWIDTH-1:0] mplier_next;
    logic [PW:0]          sum;
    logic                 rem_ge_div;

    seq_recombine_shift_add_step #(
        .DATAWIDTH(DATAWIDTH)
    ) u_step (
        .acc        (acc),
        .mcand      (mcand),
        .mplier     (mplier),
        .acc_next   (acc_next),
        .mcand_next (mcand_next),
        .mplier_next(mplier_next)
    );

    // Final addition of the remainder and the remainder/divisor consistency compare.
    always_comb begin
        sum        = {1'b0, acc} + {{(PW + 1 - DATAWIDTH){1'b0}}, rem_q};
        rem_ge_div = (rem_q >= div_q);
    end

    // Controller, datapath registers and registered handshake/result outputs.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            dividend  <= '0;
            ovf       <= 1'b0;
            rem_err   <= 1'b0;
            div_zero  <= 1'b0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            rem_q     <= '0;
            div_q     <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        acc      <= '0;
                        mcand    <= {{DATAWIDTH{1'b0}}, divisor};
                        mplier   <= quot;
                        rem_q    <= rem;
                        div_q    <= divisor;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= MUL;
                    end
                end
                MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand_next;
                    mplier <= mplier_next;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(DATAWIDTH - 1)) begin
                        state <= ADD;
                    end
                end
                ADD: begin
                    dividend  <= sum[DATAWIDTH-1:0];
                    ovf       <= |sum[PW:DATAWIDTH];
                    div_zero  <= (div_q == '0);
                    rem_err   <= (div_q != '0) && rem_ge_div;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
